// File: rtl/uart_pkg.sv
// uart_pkg: shared types and line-level constants for the UART transmit path.
package uart_pkg;

   // Transmit frame sequencer states
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Line levels for the framing bits
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Parity mode encodings
   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH x DATA_W first-word-fall-through holding FIFO.
// The head word is presented on dout whenever the FIFO is non-empty.
// A full FIFO refuses writes even if a pop happens on the same edge.
module uart_tx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [DATA_W-1:0]            din,
   input  logic                         pop,
   output logic [DATA_W-1:0]            dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [LW-1:0]     cnt;
   logic              do_push, do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + LW'(1);
            2'b01:   cnt <= cnt - LW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (cnt == LW'(DEPTH));
   assign empty = (cnt == '0);
   assign level = cnt;

endmodule

// File: rtl/uart_tx_frm.sv
// uart_tx_frm: buffered UART transmitter, LSB first, paced by bclk.
// Frames are start + DATA_W data + optional parity + STOP_BITS stop bits,
// sent back to back while words are queued.
// Define UART_TX_PARITY_EN to compile in the parity bit (mode PARITY_ODD).
module uart_tx_frm #(
   parameter int DATA_W     = 8,
   parameter int STOP_BITS  = 1,
   parameter int DEPTH      = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         bclk,
   input  logic [DATA_W-1:0]            din,
   input  logic                         en,
   output logic                         tx_rdy,
   output logic                         txd,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

   import uart_pkg::*;

   localparam int CW = $clog2(DATA_W);

   tx_state_t         state, state_n;
   logic [DATA_W-1:0] sr, sr_n, head;
   logic [CW-1:0]     bit_cnt, bit_cnt_n;
   logic              stop_cnt, stop_cnt_n;
   logic              txd_n;
   logic              pop, full, empty;
`ifdef UART_TX_PARITY_EN
   localparam logic ODD_SEL = (PARITY_ODD != 0) ? PARITY_ODD_MODE() : PARITY_EVEN;
   logic par_acc, par_acc_n;
   function automatic logic PARITY_ODD_MODE();
      return uart_pkg::PARITY_ODD;
   endfunction
`endif

   uart_tx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (en),
      .din   (din),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   assign tx_rdy = ~full;
   assign busy   = (state != IDLE) || (fifo_level != '0);

   // Frame sequencer: all state and txd changes happen only on bclk ticks
   always_comb begin
      state_n    = state;
      sr_n       = sr;
      bit_cnt_n  = bit_cnt;
      stop_cnt_n = stop_cnt;
      txd_n      = txd;
      pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_acc_n  = par_acc;
`endif
      if (bclk) begin
         case (state)
            IDLE: begin
               txd_n = STOP_BIT;
               if (!empty) begin
                  sr_n    = head;
                  pop     = 1'b1;
                  txd_n   = START_BIT;
                  state_n = START;
`ifdef UART_TX_PARITY_EN
                  par_acc_n = 1'b0;
`endif
               end
            end
            START: begin
               txd_n     = sr[0];
               sr_n      = sr >> 1;
               bit_cnt_n = '0;
               state_n   = DATA;
            end
            DATA: begin
               bit_cnt_n = bit_cnt + CW'(1);
`ifdef UART_TX_PARITY_EN
               par_acc_n = par_acc ^ txd;
`endif
               if (bit_cnt == CW'(DATA_W-1)) begin
`ifdef UART_TX_PARITY_EN
                  // txd still holds the last data bit, fold it in here
                  txd_n   = par_acc ^ txd ^ ODD_SEL;
                  state_n = PARITY;
`else
                  txd_n      = STOP_BIT;
                  stop_cnt_n = 1'b0;
                  state_n    = STOP;
`endif
               end else begin
                  txd_n = sr[0];
                  sr_n  = sr >> 1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               txd_n      = STOP_BIT;
               stop_cnt_n = 1'b0;
               state_n    = STOP;
            end
`endif
            STOP: begin
               if (stop_cnt == 1'(STOP_BITS-1)) begin
                  if (!empty) begin
                     // chain straight into the next start bit, no idle mark
                     sr_n    = head;
                     pop     = 1'b1;
                     txd_n   = START_BIT;
                     state_n = START;
`ifdef UART_TX_PARITY_EN
                     par_acc_n = 1'b0;
`endif
                  end else begin
                     txd_n   = STOP_BIT;
                     state_n = IDLE;
                  end
               end else begin
                  stop_cnt_n = stop_cnt + 1'b1;
                  txd_n      = STOP_BIT;
               end
            end
            default: begin
               txd_n   = STOP_BIT;
               state_n = IDLE;
            end
         endcase
      end
   end

   // Sequencer registers; reset forces the line to mark immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         sr       <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         txd      <= STOP_BIT;
`ifdef UART_TX_PARITY_EN
         par_acc  <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         sr       <= sr_n;
         bit_cnt  <= bit_cnt_n;
         stop_cnt <= stop_cnt_n;
         txd      <= txd_n;
`ifdef UART_TX_PARITY_EN
         par_acc  <= par_acc_n;
`endif
      end
   end

endmodule

// File: doc/uart_tx_frm.md
# uart_tx_frm

Parametrised UART transmitter: next-generation serial transmit path of the UART controller. Accepts parallel words through a write strobe into a small holding FIFO and serialises them LSB-first on `txd` as start, data, optional parity and stop bits, paced by the one-cycle baud tick from the existing baud generator. Adds configurable word width, stop-bit count and buffering, and back-to-back framing with no idle gap between queued words.

## Interface
- `DATA_W`, 8, data bits per frame; legal range 5..9.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `PARITY_ODD`, 0, 0 selects even parity, 1 selects odd parity. Used only when parity is compiled in.

- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `bclk`  in  1  baud tick, one `clk` cycle wide, once per bit period, synchronous to `clk`.
- `din`  in  DATA_W  word to transmit.
- `en`  in  1  write strobe; `din` is captured on a `clk` edge where `en`=1 and `tx_rdy`=1.
- `tx_rdy`  out  1  FIFO not full; reset value 1.
- `txd`  out  1  serial line, registered; reset value 1 (mark).
- `busy`  out  1  frame in progress or FIFO non-empty; reset value 0.
- `fifo_level`  out  $clog2(DEPTH+1)  current FIFO occupancy; reset value 0.

## Operation
- FIFO push: `en`=1 and `tx_rdy`=1. If `en`=1 and `tx_rdy`=0, the write is ignored and the word is dropped.
- FIFO pop: a frame load by the FSM.
- Simultaneous push and pop in one cycle: both take effect and `fifo_level` is unchanged. A full FIFO cannot push, even when a pop occurs in the same cycle.
- FSM states are IDLE, START, DATA, PARITY and STOP. State advances only on cycles where `bclk`=1; `txd` updates on the same edge.
- IDLE: `txd`=1. On a tick with the FIFO non-empty: load the shift register from the FIFO head, pop, drive `txd`<=0, go to START.
- START: on a tick, drive `txd`<=sr[0], shift right, clear the bit counter, go to DATA.
- DATA: on each tick, increment the bit counter and XOR the sent bit into the parity accumulator.
  - While the counter is below DATA_W-1: drive `txd`<=next sr[0].
  - At DATA_W-1: go to PARITY and drive `txd`<=parity bit, or (no parity) go to STOP and drive `txd`<=1.
- PARITY: on a tick, drive `txd`<=1 and go to STOP.
- STOP: counts STOP_BITS ticks. On the final stop tick:
  - FIFO non-empty: load, pop and drive `txd`<=0 directly, entering START. No idle bit between frames.
  - FIFO empty: go to IDLE.
- Parity bit: XOR of all data bits for even parity; its complement for odd parity.
- `busy` = (state != IDLE) or (`fifo_level` != 0).

## Timing
- A word written at edge N is visible to the FSM from edge N+1. A `bclk` on that same edge N cannot start the word.
- Start bit begins at the first `bclk` edge after N with the FSM in IDLE.
- Frame length is exactly 1 + DATA_W + P + STOP_BITS ticks, with P = 1 when parity is compiled in and 0 otherwise.
- Reset asserted mid-frame: `txd` goes to 1 asynchronously, the FIFO is emptied and the FSM enters IDLE. The partial frame is abandoned.
- `tx_rdy` deasserts on the edge that makes the FIFO full. It reasserts on the edge of the pop that frees an entry.
- If `bclk` is held high continuously, one bit is sent per `clk` cycle. The block does not check this condition.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state and parity accumulator are present.
  - Frame carries one parity bit selected by PARITY_ODD.
- `UART_TX_PARITY_EN` undefined:
  - No PARITY state or accumulator logic is generated.
  - DATA goes directly to STOP, and PARITY_ODD is ignored.

## Structure
- Package `uart_pkg` holds:
  - the FSM state typedef (IDLE, START, DATA, PARITY, STOP);
  - constants START_BIT=0 and STOP_BIT=1;
  - parity mode constants PARITY_EVEN=0 and PARITY_ODD=1.
- Sub-module `uart_tx_fifo` (DEPTH x DATA_W, synchronous, first-word-fall-through) provides full, empty and level outputs.
- The top level contains the FSM, shift register, bit counter, stop counter and parity logic.

## Test plan
- DATA_W=8, STOP_BITS=1, no parity: write 0x55 while idle. Required `txd` per tick: 0,1,0,1,0,1,0,1,0,1, then 1 thereafter. `busy` drops after the stop tick.
- Parity enabled, write 0x07: even parity gives parity bit 1; with PARITY_ODD=1 the parity bit is 0. Frame is 11 ticks.
- DEPTH=4, no ticks, 5 consecutive writes 0x01..0x05: `fifo_level`=4 and `tx_rdy`=0 after the 4th write. The 5th word is dropped; 0x01..0x04 are later sent in order.
- Write 0x00 and 0xFF back-to-back: the stop bit of frame 1 is followed immediately by the start bit of frame 2, with no extra mark tick.
- DATA_W=7, STOP_BITS=2, write 0x7F: 1 start, 7 ones, then 2 stop ticks. The next start occurs only after both stop ticks.
- Assert `rst` low at the 4th data bit of 0xA5 with 2 words queued: `txd`=1 immediately, `fifo_level`=0, `busy`=0, `tx_rdy`=1. After release, no frame is sent.
